// File: rtl/crack_result_collector.sv
// Supervises the RC4 key-search cores: holds them in reset, then stops them on the first success or declares exhaustion.
// All outputs are registered and follow the sampled inputs by one cycle; the inputs have no backpressure.
module crack_result_collector #(
   parameter int NUM_CORES  = 4,
   parameter int KEY_WIDTH  = 24,
   parameter int IDX_WIDTH  = 2,
   parameter int CNT_WIDTH  = 32,
   parameter int RESET_HOLD = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [NUM_CORES-1:0]           core_success,
   input  logic [NUM_CORES-1:0]           core_failure,
   input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
   output logic                           core_reset_n,
   output logic                           stop,
   output logic [KEY_WIDTH-1:0]           found_key,
   output logic [IDX_WIDTH-1:0]           found_core,
   output logic                           key_found,
   output logic                           no_key,
   output logic                           busy,
   output logic [CNT_WIDTH-1:0]           cycle_count
);

   localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_SEARCH,
      S_FOUND,
      S_EXH
   } state_t;

   state_t                 state_q, state_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic [NUM_CORES-1:0]   fail_q, fail_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [KEY_WIDTH-1:0]   key_q, key_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d;
   logic                   core_rst_n_q, stop_q, key_found_q, no_key_q, busy_q;

   logic                   hit;
   logic [IDX_WIDTH-1:0]   sel_idx;
   logic [KEY_WIDTH-1:0]   sel_key;

   // Scan high to low so the lowest set success bit is the one left standing.
   always_comb begin
      hit     = |core_success;
      sel_idx = '0;
      sel_key = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (core_success[i]) begin
            sel_idx = IDX_WIDTH'(i);
            sel_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      fail_d  = fail_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE, S_FOUND, S_EXH: begin
            if (start) begin
               state_d = S_HOLD;
               hold_d  = HW'(RESET_HOLD - 1);
               fail_d  = '0;
               cnt_d   = '0;
               key_d   = '0;
               idx_d   = '0;
            end
         end
         S_HOLD: begin
            if (hold_q == '0) state_d = S_SEARCH;
            else              hold_d  = hold_q - 1'b1;
         end
         S_SEARCH: begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            fail_d = fail_q | core_failure;
            if (hit) begin
               key_d   = sel_key;
               idx_d   = sel_idx;
               state_d = S_FOUND;
            end else if (&fail_d) begin
               state_d = S_EXH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         fail_q       <= '0;
         cnt_q        <= '0;
         key_q        <= '0;
         idx_q        <= '0;
         core_rst_n_q <= 1'b0;
         stop_q       <= 1'b0;
         key_found_q  <= 1'b0;
         no_key_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         fail_q       <= fail_d;
         cnt_q        <= cnt_d;
         key_q        <= key_d;
         idx_q        <= idx_d;
         core_rst_n_q <= (state_d == S_SEARCH) || (state_d == S_FOUND) || (state_d == S_EXH);
         stop_q       <= (state_d == S_FOUND) || (state_d == S_EXH);
         key_found_q  <= (state_d == S_FOUND);
         no_key_q     <= (state_d == S_EXH);
         busy_q       <= (state_d == S_HOLD) || (state_d == S_SEARCH);
      end
   end

   assign core_reset_n = core_rst_n_q;
   assign stop         = stop_q;
   assign found_key    = key_q;
   assign found_core   = idx_q;
   assign key_found    = key_found_q;
   assign no_key       = no_key_q;
   assign busy         = busy_q;
   assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_crack_result_collector.sv
// Directed bench for crack_result_collector with CNT_WIDTH=4 so saturation is reachable quickly.
module tb_crack_result_collector;

   localparam int NC = 4;
   localparam int KW = 24;
   localparam int IW = 2;
   localparam int CW = 4;
   localparam int RH = 4;

   logic              clk;
   logic              reset_n;
   logic              start;
   logic [NC-1:0]     core_success;
   logic [NC-1:0]     core_failure;
   logic [NC*KW-1:0]  core_key;
   logic              core_reset_n;
   logic              stop;
   logic [KW-1:0]     found_key;
   logic [IW-1:0]     found_core;
   logic              key_found;
   logic              no_key;
   logic              busy;
   logic [CW-1:0]     cycle_count;

   int n_tests;
   int n_fail;
   int low_cnt;

   crack_result_collector #(
      .NUM_CORES (NC),
      .KEY_WIDTH (KW),
      .IDX_WIDTH (IW),
      .CNT_WIDTH (CW),
      .RESET_HOLD(RH)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .core_success(core_success),
      .core_failure(core_failure),
      .core_key    (core_key),
      .core_reset_n(core_reset_n),
      .stop        (stop),
      .found_key   (found_key),
      .found_core  (found_core),
      .key_found   (key_found),
      .no_key      (no_key),
      .busy        (busy),
      .cycle_count (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_key(input int idx, input logic [KW-1:0] k);
      core_key[idx*KW +: KW] = k;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts cycles with core_reset_n low after the start edge; bounded so a stuck design still ends.
   task automatic measure_hold(output int n);
      n = 0;
      while (core_reset_n == 1'b0 && n < 20) begin
         n++;
         tick();
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, ".core_reset_n"}, 64'(core_reset_n), 64'd0);
      chk({tag, ".stop"},         64'(stop),         64'd0);
      chk({tag, ".found_key"},    64'(found_key),    64'd0);
      chk({tag, ".found_core"},   64'(found_core),   64'd0);
      chk({tag, ".key_found"},    64'(key_found),    64'd0);
      chk({tag, ".no_key"},       64'(no_key),       64'd0);
      chk({tag, ".busy"},         64'(busy),         64'd0);
      chk({tag, ".cycle_count"},  64'(cycle_count),  64'd0);
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      reset_n      = 1'b0;
      start        = 1'b0;
      core_success = '0;
      core_failure = '0;
      core_key     = '0;
      repeat (2) tick();
      check_idle_outputs("reset");
      reset_n = 1'b1;
      tick();
      chk("idle.core_reset_n", 64'(core_reset_n), 64'd0);

      // 1: core 2 succeeds on the 10th search cycle
      pulse_start();
      chk("t1.busy_hold", 64'(busy), 64'd1);
      measure_hold(low_cnt);
      chk("t1.hold_len", 64'(low_cnt), 64'd4);
      chk("t1.search_cnt0", 64'(cycle_count), 64'd0);
      repeat (9) tick();
      chk("t1.cnt9", 64'(cycle_count), 64'd9);
      chk("t1.stop_pre", 64'(stop), 64'd0);
      set_key(2, 24'h3CA107);
      core_success = 4'b0100;
      tick();
      core_success = '0;
      chk("t1.stop",       64'(stop),        64'd1);
      chk("t1.key_found",  64'(key_found),   64'd1);
      chk("t1.found_key",  64'(found_key),   64'h3CA107);
      chk("t1.found_core", 64'(found_core),  64'd2);
      chk("t1.cycle_count",64'(cycle_count), 64'd10);
      chk("t1.busy",       64'(busy),        64'd0);
      chk("t1.no_key",     64'(no_key),      64'd0);
      set_key(2, 24'h555555);
      core_success = 4'b0001;
      repeat (3) tick();
      core_success = '0;
      chk("t1.hold_key", 64'(found_key),   64'h3CA107);
      chk("t1.hold_cnt", 64'(cycle_count), 64'd10);

      // 2: restart from FOUND, cores 1 and 3 succeed together
      pulse_start();
      chk("t2.stop_drop",  64'(stop),       64'd0);
      chk("t2.key_clear",  64'(found_key),  64'd0);
      chk("t2.kf_clear",   64'(key_found),  64'd0);
      chk("t2.cnt_clear",  64'(cycle_count),64'd0);
      repeat (4) tick();
      chk("t2.in_search",  64'(core_reset_n), 64'd1);
      set_key(1, 24'h111111);
      set_key(3, 24'h333333);
      core_success = 4'b1010;
      tick();
      chk("t2.found_core", 64'(found_core), 64'd1);
      chk("t2.found_key",  64'(found_key),  64'h111111);
      core_success = 4'b1000;
      set_key(3, 24'h777777);
      repeat (3) tick();
      core_success = '0;
      chk("t2.hold_core", 64'(found_core), 64'd1);
      chk("t2.hold_key",  64'(found_key),  64'h111111);

      // 3: one failure pulse per core, non-overlapping
      pulse_start();
      repeat (4) tick();
      core_failure = 4'b0001; tick();
      core_failure = 4'b0010; tick();
      core_failure = 4'b0100; tick();
      chk("t3.not_yet", 64'(no_key), 64'd0);
      chk("t3.busy",    64'(busy),   64'd1);
      core_failure = 4'b1000; tick();
      core_failure = '0;
      chk("t3.no_key",    64'(no_key),      64'd1);
      chk("t3.stop",      64'(stop),        64'd1);
      chk("t3.key_found", 64'(key_found),   64'd0);
      chk("t3.busy_off",  64'(busy),        64'd0);
      chk("t3.cnt",       64'(cycle_count), 64'd4);

      // 4: success on the cycle of the last outstanding failure wins
      pulse_start();
      chk("t4.no_key_clr", 64'(no_key), 64'd0);
      repeat (4) tick();
      core_failure = 4'b0001; tick();
      core_failure = 4'b0010; tick();
      core_failure = 4'b0100; tick();
      set_key(3, 24'hABCDEF);
      core_failure = 4'b1000;
      core_success = 4'b1000;
      tick();
      core_failure = '0;
      core_success = '0;
      chk("t4.key_found",  64'(key_found),  64'd1);
      chk("t4.found_core", 64'(found_core), 64'd3);
      chk("t4.found_key",  64'(found_key),  64'hABCDEF);
      chk("t4.no_key",     64'(no_key),     64'd0);

      // 5: asynchronous reset between edges mid-search
      pulse_start();
      repeat (7) tick();
      chk("t5.pre_cnt", 64'(cycle_count), 64'd3);
      #2 reset_n = 1'b0;
      #1;
      check_idle_outputs("t5.async");
      reset_n = 1'b1;
      tick();
      pulse_start();
      repeat (4) tick();
      chk("t5.restart_cnt", 64'(cycle_count), 64'd0);
      repeat (2) tick();
      chk("t5.cnt2", 64'(cycle_count), 64'd2);
      set_key(2, 24'h00ABCD);
      core_success = 4'b0100;
      tick();
      core_success = '0;
      chk("t5.found_key", 64'(found_key), 64'h00ABCD);

      // 6: restart from FOUND, core 0 wins, then counter saturation
      pulse_start();
      chk("t6.stop_drop",  64'(stop),       64'd0);
      chk("t6.key_clear",  64'(found_key),  64'd0);
      chk("t6.core_clear", 64'(found_core), 64'd0);
      measure_hold(low_cnt);
      chk("t6.hold_len", 64'(low_cnt), 64'd4);
      set_key(0, 24'h000001);
      core_success = 4'b0001;
      tick();
      core_success = '0;
      chk("t6.found_key",  64'(found_key),  64'h000001);
      chk("t6.found_core", 64'(found_core), 64'd0);
      chk("t6.key_found",  64'(key_found),  64'd1);

      pulse_start();
      repeat (4) tick();
      repeat (10) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6.start_ignored", 64'(cycle_count), 64'd11);
      repeat (9) tick();
      chk("t6.saturate", 64'(cycle_count), 64'd15);
      chk("t6.busy",     64'(busy),        64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
